// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the CPU clock-enable controller and its button front end.
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_DIV  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_HALT = 2'b11
  } mode_e;

  // 10 ms of stable level at 50 MHz
  localparam int DEB_CYCLES_DFLT = 500000;

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: 2-FF synchronizer, stable-level debounce and a
// one-cycle pulse on each accepted press.
module btn_debounce
  import clk_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          btn_s1, btn_s2;
  logic          level, level_d;
  logic          sync_vld, armed;
  logic [CW-1:0] deb_cnt;
  logic          differ;

  assign differ = (btn_s2 != level);

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      level    <= 1'b0;
      level_d  <= 1'b0;
      deb_cnt  <= '0;
      sync_vld <= 1'b0;
      armed    <= 1'b0;
      pulse    <= 1'b0;
    end else begin
      btn_s1   <= btn;
      btn_s2   <= btn_s1;
      sync_vld <= 1'b1;
      if (!differ) begin
        deb_cnt <= '0;
      end else if (deb_cnt == CNT_LAST) begin
        deb_cnt <= '0;
        level   <= btn_s2;
      end else begin
        deb_cnt <= deb_cnt + CW'(1);
      end
      level_d <= level;
      // A button still held through reset must be seen released before it can step.
      if (sync_vld && !btn_s1 && !btn_s2) armed <= 1'b1;
      pulse <= level & ~level_d & armed;
    end
  end

endmodule

// File: rtl/clk_step_ctrl.sv
// CPU clock-enable controller: run / divide / single-step / halt sequencing of
// cpu_ce plus a counter of executed CPU cycles.
//
// mode      | meaning
// MODE_RUN  | enable every cycle
// MODE_DIV  | one enable per div_val cycles (every cycle for div_val 0/1)
// MODE_STEP | one enable per accepted button press
// MODE_HALT | no enables
module clk_step_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH  = 21,
  parameter int DEB_CYCLES = DEB_CYCLES_DFLT,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode_sw,
  input  logic [DIV_WIDTH-1:0] div_val,
  input  logic                 step_btn,
  input  logic                 cpu_halt,
  output logic                 cpu_ce,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] cycle_cnt
);

  logic [1:0]           mode_s1;
  mode_e                mode, mode_prev;
  logic                 mode_chg, step_pulse;
  logic                 div_bypass, div_tc;
  logic [DIV_WIDTH-1:0] div_cnt, div_next;
  logic                 halted_next, ce_next;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
    .clk   (clk),
    .rst   (rst),
    .btn   (step_btn),
    .pulse (step_pulse)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_s1   <= 2'b00;
      mode      <= MODE_RUN;
      mode_prev <= MODE_RUN;
      div_cnt   <= '0;
      halted    <= 1'b0;
      cpu_ce    <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      mode_s1   <= mode_sw;
      mode      <= mode_e'(mode_s1);
      mode_prev <= mode;
      div_cnt   <= div_next;
      halted    <= halted_next;
      cpu_ce    <= ce_next;
      cycle_cnt <= cycle_cnt + CNT_WIDTH'(cpu_ce);
    end
  end

  assign mode_chg   = (mode != mode_prev);
  assign div_bypass = (div_val <= DIV_WIDTH'(1));
  assign div_tc     = (div_cnt >= div_val - DIV_WIDTH'(1));

  always_comb begin
    div_next    = '0;
    halted_next = halted;
    if (mode == MODE_DIV && !mode_chg && !div_bypass && !div_tc)
      div_next = div_cnt + DIV_WIDTH'(1);
    if (mode_chg) halted_next = 1'b0;
    if (cpu_halt) halted_next = 1'b1;
  end

  // A step pulse coinciding with a halt request or a mode change is dropped.
  always_comb begin
    ce_next = 1'b0;
    if (!halted && !cpu_halt && !mode_chg) begin
      case (mode)
        MODE_RUN:  ce_next = 1'b1;
        MODE_DIV:  ce_next = div_bypass || div_tc;
        MODE_STEP: ce_next = step_pulse;
        default:   ce_next = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Bench for clk_step_ctrl: expected cpu_ce pulse cycles are queued as stimulus
// is applied and matched against each enable the DUT produces.
module tb_clk_step_ctrl;
  import clk_ctrl_pkg::*;

  localparam int DIV_W = 21;
  localparam int DEB   = 4;
  localparam int CNT_W = 4;

  logic             clk      = 1'b0;
  logic             rst      = 1'b1;
  logic [1:0]       mode_sw  = MODE_RUN;
  logic [DIV_W-1:0] div_val  = '0;
  logic             step_btn = 1'b0;
  logic             cpu_halt = 1'b0;
  logic             cpu_ce;
  logic             halted;
  logic [CNT_W-1:0] cycle_cnt;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_exp = 0;
  int exp_q[$];

  clk_step_ctrl #(.DIV_WIDTH(DIV_W), .DEB_CYCLES(DEB), .CNT_WIDTH(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode_sw   (mode_sw),
    .div_val   (div_val),
    .step_btn  (step_btn),
    .cpu_halt  (cpu_halt),
    .cpu_ce    (cpu_ce),
    .halted    (halted),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int t);
    exp_q.push_back(t);
    n_exp++;
  endtask

  task automatic push_range(input int a, input int b);
    for (int t = a; t <= b; t++) push(t);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle(input string tag);
    chk({tag, "_cnt"}, cycle_cnt, n_exp % (1 << CNT_W));
    chk({tag, "_pending"}, exp_q.size(), 0);
  endtask

  // Leaves rst released at the current negedge; the mode register restarts in
  // RUN, so a non-RUN switch setting still yields two enables before it lands.
  task automatic do_reset(input logic [1:0] m, output int r);
    rst     = 1'b1;
    mode_sw = m;
    tick(1);
    chk("rst_ce", cpu_ce, 0);
    chk("rst_cnt", cycle_cnt, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pending", exp_q.size(), 0);
    tick(1);
    rst   = 1'b0;
    r     = cyc;
    n_exp = 0;
    if (m != MODE_RUN) push_range(r + 1, r + 2);
  endtask

  always @(negedge clk) begin
    if (cpu_ce === 1'b1) begin
      if (exp_q.size() != 0) chk("ce_time", cyc, exp_q.pop_front());
      else chk("ce_spurious", cyc, -1);
    end else if (exp_q.size() != 0 && exp_q[0] <= cyc) begin
      void'(exp_q.pop_front());
      chk("ce_missing", cpu_ce, 1);
    end
  end

  initial begin
    int r, p, m;
    logic [CNT_W-1:0] c0, d;

    tick(3);
    // RUN straight out of reset, then reset mid-run
    rst = 1'b0;
    r   = cyc;
    push_range(r + 1, r + 10);
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      chk("run_cnt", cycle_cnt, i - 1);
    end
    do_reset(MODE_HALT, r);
    tick(6);
    settle("park");

    // DIV by 3: ten pulses over 30 cycles, then div_val=1
    p       = cyc;
    mode_sw = MODE_DIV;
    div_val = 3;
    for (int k = 0; k < 10; k++) push(p + 6 + 3 * k);
    tick(34);
    settle("div3");
    div_val = 1;
    push_range(p + 35, p + 39);
    tick(5);
    mode_sw = MODE_HALT;
    push_range(p + 40, p + 41);
    tick(6);
    settle("div1");

    // STEP: long hold, release, short glitch, minimum accepted press
    mode_sw = MODE_STEP;
    tick(5);
    p        = cyc;
    step_btn = 1'b1;
    push(p + 8);
    tick(20);
    step_btn = 1'b0;
    tick(12);
    step_btn = 1'b1;
    tick(DEB - 1);
    step_btn = 1'b0;
    tick(12);
    settle("step_hold");
    p        = cyc;
    step_btn = 1'b1;
    push(p + 8);
    tick(DEB);
    step_btn = 1'b0;
    tick(12);
    settle("step_min");

    // five clean presses
    c0 = cycle_cnt;
    for (int k = 0; k < 5; k++) begin
      p        = cyc;
      step_btn = 1'b1;
      push(p + 8);
      tick(8);
      step_btn = 1'b0;
      tick(10);
    end
    d = cycle_cnt - c0;
    chk("step5_delta", d, 5);
    settle("step5");

    // press accepted in HALT is not carried into STEP
    mode_sw = MODE_HALT;
    tick(5);
    step_btn = 1'b1;
    tick(12);
    mode_sw = MODE_STEP;
    tick(10);
    step_btn = 1'b0;
    tick(10);
    settle("halt_press");

    // halt request coinciding with the step pulse wins
    p        = cyc;
    step_btn = 1'b1;
    tick(7);
    cpu_halt = 1'b1;
    tick(1);
    cpu_halt = 1'b0;
    chk("halt_win", halted, 1);
    step_btn = 1'b0;
    tick(10);
    mode_sw = MODE_HALT;
    tick(5);
    chk("halt_clear", halted, 0);
    settle("halt_step");

    // reset while the press is still being debounced
    mode_sw = MODE_STEP;
    tick(5);
    step_btn = 1'b1;
    tick(DEB);
    do_reset(MODE_STEP, r);
    tick(15);
    settle("rst_deb_held");
    step_btn = 1'b0;
    tick(10);
    p        = cyc;
    step_btn = 1'b1;
    push(p + 8);
    tick(10);
    step_btn = 1'b0;
    tick(10);
    settle("rst_deb_again");

    // RUN, CPU halt, released by a mode change
    mode_sw = MODE_HALT;
    div_val = 3;
    tick(5);
    p       = cyc;
    mode_sw = MODE_RUN;
    push_range(p + 4, p + 8);
    tick(8);
    cpu_halt = 1'b1;
    tick(1);
    cpu_halt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("halted_hold", halted, 1);
      tick(1);
    end
    m       = cyc;
    mode_sw = MODE_DIV;
    tick(3);
    mode_sw = MODE_RUN;
    tick(1);
    chk("halt_release", halted, 0);
    push_range(m + 7, m + 14);
    tick(8);
    mode_sw = MODE_HALT;
    tick(6);
    settle("resume");

    // cycle counter wraps without saturating
    do_reset(MODE_RUN, r);
    push_range(r + 1, r + 17);
    tick(15);
    chk("wrap_14", cycle_cnt, 14);
    mode_sw = MODE_HALT;
    tick(1);
    chk("wrap_15", cycle_cnt, 15);
    tick(1);
    chk("wrap_0", cycle_cnt, 0);
    tick(1);
    chk("wrap_1", cycle_cnt, 1);
    tick(5);
    settle("wrap");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
